// File: rtl/text_console_buffer.sv
// Character-buffer controller for the VGA text display.
// It accepts ASCII characters over a valid/ready handshake and keeps a
// COLS x ROWS character array with a cursor. It handles backspace, newline
// and form-feed clear. At the bottom of the screen it either wraps to row 0
// or scrolls the screen up one row. A registered read port serves the pixel
// lookup path.
module text_console_buffer #(
   parameter int          COLS      = 12,
   parameter int          ROWS      = 9,
   parameter bit          SCROLL_EN = 1'b1,
   parameter logic [7:0]  FILL_CHAR = 8'h20,
   parameter int          ADDR_W    = $clog2(COLS*ROWS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [7:0]                ch_in,
   input  logic                      ch_valid,
   output logic                      ch_ready,
   input  logic [ADDR_W-1:0]         rd_addr,
   output logic [7:0]                rd_data,
   output logic [$clog2(COLS)-1:0]   cursor_col,
   output logic [$clog2(ROWS)-1:0]   cursor_row,
   output logic                      busy
);

   localparam int COL_W        = $clog2(COLS);
   localparam int ROW_W        = $clog2(ROWS);
   localparam int DEPTH        = COLS * ROWS;
   localparam int SCROLL_CELLS = (ROWS - 1) * COLS;

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] SCROLL_END = ADDR_W'(SCROLL_CELLS);
   localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
   localparam logic [ADDR_W:0]   DEPTH_X    = (ADDR_W+1)'(DEPTH);
   localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS - 1);

   localparam logic [7:0] CH_BS = 8'h08;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_FF = 8'h0C;

   typedef enum logic [1:0] {
      S_CLEAR,
      S_IDLE,
      S_SCROLL
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   idx;
   logic [7:0]          mem [0:DEPTH-1];

   logic                accept;
   logic                is_print;
   logic [ADDR_W-1:0]   cur_addr;
   logic [COL_W-1:0]    col_nxt;
   logic [ROW_W-1:0]    row_nxt;
   logic                row_adv;
   logic                scroll_go;
   logic                clear_go;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [7:0]          wr_data;

   assign ch_ready = (state == S_IDLE);
   assign busy     = (state != S_IDLE);
   assign accept   = ch_valid && (state == S_IDLE);
   assign is_print = (ch_in >= 8'h20) && (ch_in <= 8'h7E);
   assign cur_addr = ADDR_W'(cursor_row) * COLS_A + ADDR_W'(cursor_col);

   // Decode the accepted character into a next cursor position and a write
   // request. The fill/scroll engines share the same write port.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned; otherwise synthesis would infer a latch.
      col_nxt   = cursor_col;
      row_nxt   = cursor_row;
      row_adv   = 1'b0;
      scroll_go = 1'b0;
      clear_go  = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = idx;
      wr_data   = FILL_CHAR;
      case (state)
         S_CLEAR: wr_en = 1'b1;
         S_SCROLL: begin
            wr_en = 1'b1;
            if (idx < SCROLL_END) wr_data = mem[idx + COLS_A];
         end
         S_IDLE: begin
            if (accept) begin
               if (is_print) begin
                  wr_en   = 1'b1;
                  wr_addr = cur_addr;
                  wr_data = ch_in;
                  if (cursor_col < LAST_COL) begin
                     col_nxt = cursor_col + COL_W'(1);
                  end else begin
                     col_nxt = '0;
                     row_adv = 1'b1;
                  end
               end else if (ch_in == CH_LF) begin
                  col_nxt = '0;
                  row_adv = 1'b1;
               end else if (ch_in == CH_BS) begin
                  // The cell to the left is always cur_addr-1, including the
                  // wrap back to the last column of the previous row.
                  if (cursor_col != '0) begin
                     col_nxt = cursor_col - COL_W'(1);
                     wr_en   = 1'b1;
                     wr_addr = cur_addr - ADDR_W'(1);
                  end else if (cursor_row != '0) begin
                     row_nxt = cursor_row - ROW_W'(1);
                     col_nxt = LAST_COL;
                     wr_en   = 1'b1;
                     wr_addr = cur_addr - ADDR_W'(1);
                  end
               end else if (ch_in == CH_FF) begin
                  col_nxt  = '0;
                  row_nxt  = '0;
                  clear_go = 1'b1;
               end
            end
         end
         default: ;
      endcase

      if (row_adv) begin
         if (cursor_row < LAST_ROW) begin
            row_nxt = cursor_row + ROW_W'(1);
         end else if (SCROLL_EN) begin
            scroll_go = 1'b1;
         end else begin
            row_nxt = '0;
         end
      end

      if (!reset) wr_en = 1'b0;
   end

   // Control FSM: state, sweep index and cursor registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      if (!reset) begin
         state      <= S_CLEAR;
         idx        <= '0;
         cursor_col <= '0;
         cursor_row <= '0;
      end else begin
         cursor_col <= col_nxt;
         cursor_row <= row_nxt;
         case (state)
            S_CLEAR, S_SCROLL: begin
               if (idx == LAST_ADDR) begin
                  state <= S_IDLE;
                  idx   <= '0;
               end else begin
                  idx <= idx + ADDR_W'(1);
               end
            end
            S_IDLE: begin
               if (clear_go) begin
                  state <= S_CLEAR;
                  idx   <= '0;
               end else if (scroll_go) begin
                  state <= S_SCROLL;
                  idx   <= '0;
               end
            end
            default: state <= S_CLEAR;
         endcase
      end
   end

   // Character array write port.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; the CLEAR sweep initialises it, which
      // keeps it mappable to block RAM.
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Display read port: one cycle latency. It returns the pre-write value
   // on a same-address collision. Out-of-range addresses read as fill.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_data <= 8'h00;
      end else if ({1'b0, rd_addr} < DEPTH_X) begin
         rd_data <= mem[rd_addr];
      end else begin
         rd_data <= FILL_CHAR;
      end
   end

endmodule

// File: doc/text_console_buffer.md
Name: text_console_buffer

Overview:
Parametrised character-buffer controller for the VGA text display. Accepts translated ASCII characters over a valid/ready handshake and maintains a COLS x ROWS character array with a cursor. Supports backspace, newline, form-feed clear, and either wrap-to-top or hardware scroll at the bottom of the screen. Exposes a registered read port for the pixel/sprite lookup path.

Parameters:
COLS, 12, characters per row (>=2)
ROWS, 9, character rows (>=2)
SCROLL_EN, 1, 1 = scroll up one row at bottom; 0 = wrap cursor to row 0
FILL_CHAR, 8'h20, value written by clear, scroll fill and backspace
ADDR_W, $clog2(COLS*ROWS), buffer address width (derived; do not override)

Ports:
clk  in  1  system clock (100 MHz); all logic on posedge
reset  in  1  synchronous, active-low reset
ch_in  in  8  ASCII character
ch_valid  in  1  ch_in valid
ch_ready  out  1  block can accept a character this cycle
rd_addr  in  ADDR_W  display read address (row*COLS + col)
rd_data  out  8  character at rd_addr, 1-cycle latency
cursor_col  out  $clog2(COLS)  current cursor column
cursor_row  out  $clog2(ROWS)  current cursor row
busy  out  1  high during CLEAR or SCROLL

Behaviour:
- Memory: COLS*ROWS x 8 array. One write per cycle; one internal read (scroll) plus the independent display read port.
- States: CLEAR, IDLE, SCROLL. busy = (state != IDLE). ch_ready = (state == IDLE).
- Reset (reset==0 at posedge): state <= CLEAR, clear index <= 0, cursor <= (0,0), rd_data <= 0. Reset mid-scroll/mid-clear aborts and restarts CLEAR.
- CLEAR: writes FILL_CHAR to address idx, idx++ each cycle; after address COLS*ROWS-1 is written -> IDLE. Duration exactly COLS*ROWS cycles.
- Accept = ch_valid && ch_ready. Only accepted characters act; one character per cycle max.
- Printable (8'h20..8'h7E): write ch_in at cursor; then advance.
- 8'h0A newline: no write; col <= 0, then row-advance.
- 8'h08 backspace: col>0 -> col--, write FILL_CHAR at new position. col==0,row>0 -> row--, col<=COLS-1, write FILL_CHAR there. At (0,0): no-op.
- 8'h0C form feed: cursor <= (0,0), state <= CLEAR.
- Any other code: accepted and discarded; no state change.
- Advance: col<COLS-1 -> col++. col==COLS-1 -> col<=0 and row-advance.
- Row-advance: row<ROWS-1 -> row++. row==ROWS-1: SCROLL_EN=0 -> row<=0 (existing text kept, overwritten in place); SCROLL_EN=1 -> row stays ROWS-1, state <= SCROLL.
- SCROLL: idx from 0. For idx < (ROWS-1)*COLS: mem[idx] <= mem[idx+COLS]; for idx >= (ROWS-1)*COLS: mem[idx] <= FILL_CHAR. One cell per cycle; after idx==COLS*ROWS-1 -> IDLE. Duration exactly COLS*ROWS cycles. The character triggering the scroll is written before scrolling begins (so it moves up one row).
- Display read: rd_data <= mem[rd_addr] every cycle regardless of state (transient content during CLEAR/SCROLL permitted). rd_addr >= COLS*ROWS returns FILL_CHAR.
- Same-cycle write and read of one address: rd_data returns the old value.
- cursor outputs are registered, update the cycle after accept.

Test Plan:
- Reset low 1 cycle, release -> busy=1 for 108 cycles, ch_ready=1 on cycle 109; every address reads 8'h20; cursor (0,0).
- Send "A","B" (8'h41,8'h42) -> addr0=8'h41, addr1=8'h42, cursor (2,0); rd_data valid 1 cycle after rd_addr.
- 12 x 8'h58 then 8'h0A -> row 0 all 8'h58, cursor (0,2); backspace twice -> cursor (10,1), addr 22 and 23 = 8'h20.
- SCROLL_EN=1: fill 108 cells with row r = 8'h30+r -> on 108th char busy=1 for 108 cycles; afterwards row r holds 8'h31+r for r<8, row 8 = 8'h20, cursor (0,8); ch_valid held high during scroll is not accepted.
- SCROLL_EN=0, same fill -> no busy, cursor (0,0), contents unchanged; next char 8'h5A overwrites addr0.
- Mid-scroll reset low -> scroll aborted, CLEAR runs full 108 cycles, all cells 8'h20; 8'h0C in IDLE -> same clear, cursor (0,0); 8'h07 -> accepted, no change.
